// File: rtl/pcf_pkg.sv
// pcf_pkg: shared definitions for the PC/fetch block.
//   - next-PC select encodings (NPC_SEQ/NPC_BR/NPC_J/NPC_JR)
//   - fetch FSM state encodings
//   - default reset PC
package pcf_pkg;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } pcf_state_e;

  localparam logic [31:0] PCF_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/npc_mux.sv
// npc_mux: combinational redirect-target selection.
// Ports:
//   redir_sel   in  2  : NPC_SEQ / NPC_BR / NPC_J / NPC_JR
//   redir_pc4   in  32 : PC+4 of the redirecting instruction
//   br_offset   in  16 : branch immediate (word offset, signed)
//   jump_target in  32 : result of the jump concatenation stage
//   jr_target   in  32 : rs value for JR
//   target      out 32 : selected target, wraps mod 2^32
module npc_mux
  import pcf_pkg::*;
(
  input  logic [1:0]  redir_sel,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] br_offset,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] target
);

  logic signed [31:0] br_disp;
  logic        [31:0] br_target;

  // Sign-extended immediate scaled to bytes; the add wraps naturally.
  assign br_disp   = {{14{br_offset[15]}}, br_offset, 2'b00};
  assign br_target = redir_pc4 + br_disp;

  always_comb begin
    target = redir_pc4;
    case (redir_sel)
      NPC_SEQ: target = redir_pc4;
      NPC_BR:  target = br_target;
      NPC_J:   target = jump_target;
      NPC_JR:  target = jr_target;
      default: target = redir_pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC and single-outstanding instruction fetch.
// Configuration macro: PCF_ALIGN_CHECK_EN (misaligned-JR detection).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   imem_req/addr/ack/rdata    : instruction memory request channel
//   inst_valid/ready, inst,
//   inst_pc                    : fetched instruction towards decode
//   pc4_hi, instr_index        : operands for the jump concatenation stage
//   redir_valid/sel/pc4,
//   br_offset, jump_target,
//   jr_target                  : redirect inputs
//   misalign                   : one-cycle pulse on misaligned JR
module pc_fetch
  import pcf_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [3:0]  pc4_hi,
  output logic [25:0] instr_index,
  input  logic        redir_valid,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] br_offset,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        misalign
);

  pcf_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] raw_tgt;
  logic [31:0] tgt;
  logic        redir;
  logic        bad_jr;
  logic [31:0] inst_pc4;

  npc_mux u_npc_mux (
    .redir_sel   (redir_sel),
    .redir_pc4   (redir_pc4),
    .br_offset   (br_offset),
    .jump_target (jump_target),
    .jr_target   (jr_target),
    .target      (raw_tgt)
  );

`ifdef PCF_ALIGN_CHECK_EN
  // A misaligned JR is reported and otherwise ignored: no PC change, no drop.
  assign bad_jr = redir_valid && (redir_sel == NPC_JR) && (raw_tgt[1:0] != 2'b00);
  assign redir  = redir_valid && !bad_jr;
  assign tgt    = raw_tgt;
`else
  assign bad_jr = 1'b0;
  assign redir  = redir_valid;
  assign tgt    = raw_tgt & ~32'h3;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = bad_jr;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir) begin
          pc_d   = tgt;
          addr_d = tgt;
        end else begin
          addr_d = pc_q;
        end
      end
      S_REQ: begin
        if (redir) begin
          pc_d = tgt;
          if (imem_ack) begin
            // Returned word belongs to the old path; reissue at the target.
            state_d = S_REQ;
            addr_d  = tgt;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          state_d   = S_HOLD;
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
          pc_d    = tgt;
          addr_d  = tgt;
        end else if (inst_ready) begin
          state_d = S_REQ;
          addr_d  = pc_q;
        end
      end
      S_DROP: begin
        if (redir) begin
          pc_d = tgt;
          // If the stale request completes in the same cycle, go straight
          // to the new target instead of waiting on an ack that never comes.
          if (imem_ack) begin
            state_d = S_REQ;
            addr_d  = tgt;
          end
        end else if (imem_ack) begin
          state_d = S_REQ;
          addr_d  = pc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign inst_pc4    = inst_pc_q + 32'd4;
  assign imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr   = addr_q;
  assign inst_valid  = (state_q == S_HOLD);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign pc4_hi      = inst_pc4[31:28];
  assign instr_index = inst_q[25:0];
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [3:0]  pc4_hi;
  logic [25:0] instr_index;
  logic        redir_valid;
  logic [1:0]  redir_sel;
  logic [31:0] redir_pc4;
  logic [15:0] br_offset;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        misalign;

  // Memory model: auto mode acks every request with a word derived from the
  // address; manual mode lets the sequence drive ack/data directly.
  logic        auto_mem;
  logic        man_ack;
  logic [31:0] man_rdata;
  assign imem_ack   = auto_mem ? imem_req : man_ack;
  assign imem_rdata = auto_mem ? (imem_addr ^ 32'hA5A5_0000) : man_rdata;

  int checks;
  int failures;

  pc_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc4_hi      (pc4_hi),
    .instr_index (instr_index),
    .redir_valid (redir_valid),
    .redir_sel   (redir_sel),
    .redir_pc4   (redir_pc4),
    .br_offset   (br_offset),
    .jump_target (jump_target),
    .jr_target   (jr_target),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk(tag, {31'b0, imem_req}, 32'h1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    auto_mem    = 1'b1;
    man_ack     = 1'b0;
    man_rdata   = 32'h0;
    inst_ready  = 1'b1;
    redir_valid = 1'b0;
    redir_sel   = 2'd0;
    redir_pc4   = 32'h0;
    br_offset   = 16'h0;
    jump_target = 32'h0;
    jr_target   = 32'h0;

    // Reset values
    step();
    step();
    chk("rst_req",      {31'b0, imem_req},   32'h0);
    chk("rst_valid",    {31'b0, inst_valid}, 32'h0);
    chk("rst_inst",     inst,                32'h0);
    chk("rst_inst_pc",  inst_pc,             32'h0);
    chk("rst_addr",     imem_addr,           32'h0040_0000);
    chk("rst_misalign", {31'b0, misalign},   32'h0);

    // Free run: ack every request, ready high
    rst_n = 1'b1;
    wait_req("run_req0");
    chk("run_addr0", imem_addr, 32'h0040_0000);
    step();
    chk("run_valid0", {31'b0, inst_valid}, 32'h1);
    chk("run_pc0",    inst_pc,             32'h0040_0000);
    chk("run_inst0",  inst,                32'hA5E5_0000);
    chk("run_hi0",    {28'b0, pc4_hi},     32'h0);
    step();
    chk("run_addr1", imem_addr, 32'h0040_0004);
    step();
    chk("run_pc1", inst_pc, 32'h0040_0004);
    step();
    chk("run_addr2", imem_addr, 32'h0040_0008);

    // Stall: ready low for 5 cycles with a J instruction held
    auto_mem   = 1'b0;
    man_ack    = 1'b1;
    man_rdata  = 32'h0810_0004;
    inst_ready = 1'b0;
    step();
    man_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, inst_valid}, 32'h1);
      chk("stall_inst",  inst,                32'h0810_0004);
      chk("stall_pc",    inst_pc,             32'h0040_0008);
      chk("stall_req",   {31'b0, imem_req},   32'h0);
      chk("stall_index", {6'b0, instr_index}, 32'h0010_0004);
      step();
    end

    // Branch redirect from S_HOLD: 0x00400010 + (-1 << 2) = 0x0040000C
    redir_valid = 1'b1;
    redir_sel   = 2'd1;
    redir_pc4   = 32'h0040_0010;
    br_offset   = 16'hFFFF;
    step();
    redir_valid = 1'b0;
    chk("br_addr",  imem_addr,           32'h0040_000C);
    chk("br_req",   {31'b0, imem_req},   32'h1);
    chk("br_valid", {31'b0, inst_valid}, 32'h0);

    // Jump redirect while the request is outstanding; ack arrives later
    redir_valid = 1'b1;
    redir_sel   = 2'd2;
    jump_target = 32'h0050_0000;
    step();
    redir_valid = 1'b0;
    chk("drop_req",  {31'b0, imem_req}, 32'h1);
    chk("drop_addr", imem_addr,         32'h0040_000C);
    step();
    step();
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();
    chk("drop_valid", {31'b0, inst_valid}, 32'h0);
    chk("drop_naddr", imem_addr,           32'h0050_0000);
    chk("drop_nreq",  {31'b0, imem_req},   32'h1);
    man_rdata  = 32'h1111_2222;
    inst_ready = 1'b1;
    step();
    man_ack = 1'b0;
    chk("tgt_inst", inst,    32'h1111_2222);
    chk("tgt_pc",   inst_pc, 32'h0050_0000);

    // JR to a misaligned address from S_HOLD (ready high)
    redir_valid = 1'b1;
    redir_sel   = 2'd3;
    jr_target   = 32'h0040_0022;
    step();
    redir_valid = 1'b0;
`ifdef PCF_ALIGN_CHECK_EN
    chk("jr_misalign", {31'b0, misalign}, 32'h1);
    chk("jr_addr",     imem_addr,         32'h0050_0004);
`else
    chk("jr_misalign", {31'b0, misalign}, 32'h0);
    chk("jr_addr",     imem_addr,         32'h0040_0020);
`endif
    step();
    chk("jr_pulse_end", {31'b0, misalign}, 32'h0);

    // Reach S_HOLD, then assert reset mid-cycle
    man_ack    = 1'b1;
    man_rdata  = 32'h3333_4444;
    inst_ready = 1'b0;
    step();
    man_ack = 1'b0;
    chk("hold_valid", {31'b0, inst_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, inst_valid}, 32'h0);
    chk("arst_req",   {31'b0, imem_req},   32'h0);
    chk("arst_inst",  inst,                32'h0);
    chk("arst_pc",    inst_pc,             32'h0);
    chk("arst_addr",  imem_addr,           32'h0040_0000);
    step();
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    wait_req("restart_req");
    chk("restart_addr", imem_addr, 32'h0040_0000);

    // Redirect with ack in the same cycle, then PC wrap at the top of memory
    redir_valid = 1'b1;
    redir_sel   = 2'd2;
    jump_target = 32'hFFFF_FFFC;
    man_ack     = 1'b1;
    man_rdata   = 32'h9999_9999;
    step();
    redir_valid = 1'b0;
    chk("same_valid", {31'b0, inst_valid}, 32'h0);
    chk("same_addr",  imem_addr,           32'hFFFF_FFFC);
    man_rdata = 32'h0000_0055;
    step();
    man_ack = 1'b0;
    chk("wrap_inst", inst,            32'h0000_0055);
    chk("wrap_pc",   inst_pc,         32'hFFFF_FFFC);
    chk("wrap_hi",   {28'b0, pc4_hi}, 32'h0);
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
